// File: rtl/stack_calc_pkg.sv
// stack_calc_pkg: opcode, error-code and FSM-state encodings shared by the stack calculator.
package stack_calc_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_PUSH, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OUT, OP_ILL} opcode_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_UNDER, ERR_OVER, ERR_ILL} err_e;
  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP1, S_POP2, S_CAPA, S_WRITE} state_e;
endpackage

// File: rtl/stack_calc_alu.sv
// stack_calc_alu: unsigned modulo-2^N binary operation on the two popped operands.
module stack_calc_alu import stack_calc_pkg::*; #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  opcode_e      op,
  output logic [N-1:0] y
);
  always_comb y = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_MUL ? a * b : a & b;
endmodule

// File: rtl/stack_calc_ctrl.sv
// stack_calc_ctrl: instruction sequencer driving an external stack for a tiny RPN calculator.
module stack_calc_ctrl import stack_calc_pkg::*; #(
  parameter int N = 16,
  parameter int STACK_SIZE = 16,
  localparam int DW = $clog2(STACK_SIZE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    opcode,
  input  logic [N-1:0]  operand,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [N-1:0]  stk_push_data,
  input  logic [N-1:0]  stk_pop_data,
  output logic [N-1:0]  result,
  output logic          result_valid,
  output logic          busy,
  output logic [DW-1:0] depth,
  output logic [1:0]    err,
  input  logic          err_clr
);
  state_e state_q, state_d;
  opcode_e op_q, op_d, opc;
  err_e err_q, err_d, err_chk;
  logic [N-1:0] a_q, a_d, b_q, b_d, opnd_q, opnd_d, result_q, result_d, alu_y;
  logic [DW-1:0] depth_q, depth_d;
  logic push_q, push_d, pop_q, pop_d, rvalid_q, rvalid_d, accept;
  stack_calc_alu #(.N(N)) u_alu (.a(a_q), .b(b_q), .op(op_q), .y(alu_y));
  assign instr_ready   = state_q == S_IDLE;
  assign busy          = state_q != S_IDLE;
  assign stk_push      = push_q;
  assign stk_pop       = pop_q;
  assign stk_push_data = state_q == S_WRITE ? alu_y : opnd_q;
  assign result        = result_q;
  assign result_valid  = rvalid_q;
  assign depth         = depth_q;
  assign err           = err_q;
  always_comb begin
    opc     = opcode_e'(opcode);
    accept  = instr_valid && state_q == S_IDLE;
    err_chk = opc == OP_PUSH && depth_q == DW'(STACK_SIZE) ? ERR_OVER :
              opc inside {OP_ADD, OP_SUB, OP_MUL, OP_AND} && depth_q < DW'(2) ? ERR_UNDER :
              opc == OP_OUT && depth_q == '0 ? ERR_UNDER :
              opc == OP_ILL ? ERR_ILL : ERR_NONE;
    err_d    = err_clr ? ERR_NONE : accept && err_q == ERR_NONE ? err_chk : err_q;
    depth_d  = depth_q + DW'(push_q) - DW'(pop_q);
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: if (accept && err_chk == ERR_NONE && opc != OP_NOP) begin
        op_d    = opc;
        state_d = opc == OP_PUSH ? S_PUSH : S_POP1;
        push_d  = opc == OP_PUSH;
        pop_d   = opc != OP_PUSH;
        opnd_d  = opc == OP_PUSH ? operand : opnd_q;
      end
      S_PUSH: state_d = S_IDLE;
      S_POP1: begin
        state_d = op_q == OP_OUT ? S_CAPA : S_POP2;
        pop_d   = op_q != OP_OUT;
      end
      S_POP2: begin
        b_d     = stk_pop_data;
        state_d = S_CAPA;
      end
      S_CAPA: begin
        a_d      = stk_pop_data;
        state_d  = op_q == OP_OUT ? S_IDLE : S_WRITE;
        push_d   = op_q != OP_OUT;
        result_d = op_q == OP_OUT ? stk_pop_data : result_q;
        rvalid_d = op_q == OP_OUT;
      end
      S_WRITE: begin
        result_d = alu_y;
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      err_q    <= ERR_NONE;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      depth_q  <= '0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      depth_q  <= depth_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      rvalid_q <= rvalid_d;
    end
  end
endmodule

// File: doc/stack_calc_ctrl.md
STACK_CALC_CTRL -- requirements
Module: stack_calc_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning the data word width.
REQ-002 The block SHALL have parameter STACK_SIZE, default 16, meaning the attached stack's capacity in words.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port instr_valid, input, 1 bit: an instruction is offered.
REQ-006 The block SHALL have port instr_ready, output, 1 bit: the offered instruction is accepted this cycle.
REQ-007 The block SHALL have port opcode, input, 3 bits: 0 NOP, 1 PUSH, 2 ADD, 3 SUB, 4 MUL, 5 AND, 6 OUT, 7 illegal.
REQ-008 The block SHALL have port operand, input, N bits: the immediate value for PUSH.
REQ-009 The block SHALL have ports stk_push and stk_pop, outputs, 1 bit each: strobes to the stack.
REQ-010 The block SHALL have port stk_push_data, output, N bits: the word to push.
REQ-011 The block SHALL have port stk_pop_data, input, N bits: the popped word, valid in the cycle after a pop strobe.
REQ-012 The block SHALL have port result, output, N bits: the last arithmetic result or the last OUT value.
REQ-013 The block SHALL have port result_valid, output, 1 bit: a one-cycle pulse when result updates.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have port depth, output, $clog2(STACK_SIZE+1) bits: the controller's count of stack occupancy.
REQ-016 The block SHALL have port err, output, 2 bits: sticky error code (00 none, 01 underflow, 10 overflow, 11 illegal opcode).
REQ-017 The block SHALL have port err_clr, input, 1 bit: synchronously clears err.

Function
REQ-018 The FSM SHALL have the states IDLE, PUSH, POP1, POP2, CAPA, WRITE.
REQ-019 instr_ready SHALL equal (state==IDLE); an instruction SHALL be accepted when instr_valid && instr_ready.
REQ-020 On accept, the block SHALL check legality against depth before any stack strobe:
 - PUSH with depth==STACK_SIZE -> overflow.
 - ADD/SUB/MUL/AND with depth<2 -> underflow.
 - OUT with depth==0 -> underflow.
 - opcode 7 -> illegal.
REQ-021 An errored instruction SHALL be consumed and not executed: no strobe, depth unchanged, err loaded next cycle, FSM stays IDLE.
REQ-022 When err is nonzero, a new error SHALL NOT overwrite it (first error wins); err_clr takes priority over a same-cycle new error.
REQ-023 NOP SHALL be consumed with no effect and no busy cycle.
REQ-024 PUSH SHALL go IDLE->PUSH, assert stk_push with stk_push_data=operand for one cycle, increment depth, then return to IDLE (2 cycles total).
REQ-025 Binary operations SHALL follow this sequence:
 - POP1: stk_pop=1.
 - POP2: stk_pop=1; capture b=stk_pop_data.
 - CAPA: capture a=stk_pop_data.
 - WRITE: stk_push=1 with f(a,b); result=f(a,b); result_valid pulse in the following cycle; return to IDLE.
 - depth is net -1 over the sequence.
REQ-026 Operation results SHALL be: ADD a+b, SUB a-b, MUL low N bits of a*b, AND a&b; all modulo 2^N, unsigned, no saturation or carry out.
REQ-027 OUT SHALL follow IDLE->POP1 (stk_pop)->CAPA; in CAPA result=stk_pop_data with a result_valid pulse next cycle; then IDLE; depth -1.
REQ-028 stk_push and stk_pop SHALL never be asserted in the same cycle, and neither SHALL be asserted outside the states named above.
REQ-029 depth SHALL stay within 0..STACK_SIZE at all times; it never wraps.
REQ-030 instr_valid and opcode SHALL be ignored while busy.

Reset
REQ-031 Reset SHALL force, immediately and asynchronously: state=IDLE, stk_push=0, stk_pop=0, stk_push_data=0, result=0, result_valid=0, depth=0, err=00, and internal a/b registers to 0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence; the attached stack is reset by the same signal so that depth stays consistent with it.

Structure
REQ-033 The opcode encodings, error codes and FSM state encoding SHALL reside in a shared package, stack_calc_pkg.
REQ-034 The combinational a/b operation SHALL be a sub-module, stack_calc_alu (inputs a, b, op; output y, N bits).

Verification
REQ-035 Directed test: after reset, PUSH 5, PUSH 3, SUB -> result=2, result_valid pulses once, depth=1, stack holds 2.
REQ-036 Directed test: PUSH 0x8000, PUSH 0x0003, MUL (N=16) -> result=0x8000, depth=1.
REQ-037 Directed test: from empty, ADD -> err=01, no strobe, depth=0; a subsequent PUSH 7 then OUT -> result=7.
REQ-038 Directed test: 16 PUSHes then one more PUSH -> err=10, depth=16; a following opcode 7 leaves err=10; err_clr -> err=00.
REQ-039 Directed test: assert reset during POP2 of an ADD -> all outputs at reset values in the same cycle, instr_ready=1 after release.
REQ-040 Directed test: hold instr_valid high during an ADD sequence -> exactly one instruction is accepted per IDLE cycle, and stk_push/stk_pop are never high together.
